// File: rtl/pong_pkg.sv
// +--------------------------------------------------------------------------+
// | pong_pkg : shared pong types, overlay codes and screen constants         |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

package pong_pkg;

  typedef enum logic [1:0] {
    ST_NEWGAME = 2'd0,
    ST_PLAY    = 2'd1,
    ST_NEWBALL = 2'd2,
    ST_OVER    = 2'd3
  } state_t;

  localparam logic [1:0] c_TXT_RULES   = 2'b00;
  localparam logic [1:0] c_TXT_NONE    = 2'b01;
  localparam logic [1:0] c_TXT_NEWBALL = 2'b10;
  localparam logic [1:0] c_TXT_OVER    = 2'b11;

  localparam int MAX_X       = 640;
  localparam int MAX_Y       = 480;
  localparam int c_REFR_LINE = 481;

  function automatic logic [1:0] text_code(input state_t s);
    logic [1:0] code;
    code = c_TXT_RULES;
    case (s)
      ST_NEWGAME: code = c_TXT_RULES;
      ST_PLAY:    code = c_TXT_NONE;
      ST_NEWBALL: code = c_TXT_NEWBALL;
      ST_OVER:    code = c_TXT_OVER;
      default:    code = c_TXT_RULES;
    endcase
    return code;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pong_bcd_score.sv
// +--------------------------------------------------------------------------+
// | pong_bcd_score : two-digit BCD counter with clear and increment (00..99) |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module pong_bcd_score (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       inc,
  output logic [3:0] d1,
  output logic [3:0] d0
);

  logic [3:0] r_d1;
  logic [3:0] r_d0;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_d1 <= 4'd0;
      r_d0 <= 4'd0;
    end else if (inc) begin
      if (r_d0 == 4'd9) begin
        r_d0 <= 4'd0;
        r_d1 <= (r_d1 == 4'd9) ? 4'd0 : r_d1 + 4'd1;
      end else begin
        r_d0 <= r_d0 + 4'd1;
      end
    end
  end

  assign d1 = r_d1;
  assign d0 = r_d0;

endmodule

`default_nettype wire

// File: rtl/pong_game_ctrl.sv
// +--------------------------------------------------------------------------+
// | pong_game_ctrl : game phase sequencer, ball count, score and delay timer |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter int BALLS_INIT = 3,
  parameter int TIMER_W    = 7,
  parameter int TIMER_INIT = 127
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       refr_tick,
  input  logic [1:0] btn,
  input  logic       hit,
  input  logic       miss,
  output logic       gra_still,
  output logic [1:0] text_sel,
  output logic [3:0] score_d1,
  output logic [3:0] score_d0,
  output logic [1:0] balls_left,
  output logic       game_over
);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [TIMER_W-1:0] r_timer;
  logic [1:0]         r_balls;
  logic               r_gra_still;
  logic [1:0]         r_text_sel;
  logic               r_game_over;

  logic w_btn_press;
  logic w_timer_zero;
  logic w_timer_load;
  logic w_score_inc;
  logic w_score_clr;

  assign w_btn_press  = |btn;
  assign w_timer_zero = (r_timer == '0);

  // miss outranks hit; strobes outside PLAY fall through untouched
  always_comb begin
    w_state_nxt  = r_state;
    w_timer_load = 1'b0;
    w_score_inc  = 1'b0;
    w_score_clr  = 1'b0;
    case (r_state)
      ST_NEWGAME: begin
        if (w_btn_press) w_state_nxt = ST_PLAY;
      end
      ST_PLAY: begin
        if (miss) begin
          w_timer_load = 1'b1;
          w_state_nxt  = (r_balls == 2'd0) ? ST_OVER : ST_NEWBALL;
        end else if (hit) begin
          w_score_inc = 1'b1;
        end
      end
      ST_NEWBALL: begin
        if (w_timer_zero && w_btn_press) w_state_nxt = ST_PLAY;
      end
      ST_OVER: begin
        if (w_timer_zero) begin
          w_state_nxt = ST_NEWGAME;
          w_score_clr = 1'b1;
        end
      end
      default: w_state_nxt = ST_NEWGAME;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_NEWGAME;
      r_gra_still <= 1'b1;
      r_text_sel  <= c_TXT_RULES;
      r_game_over <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_gra_still <= (w_state_nxt != ST_PLAY);
      r_text_sel  <= text_code(w_state_nxt);
      r_game_over <= (w_state_nxt == ST_OVER);
    end
  end

  // a fresh load wins over a coincident tick
  always_ff @(posedge clk) begin
    if (rst) begin
      r_timer <= '0;
    end else if (w_timer_load) begin
      r_timer <= TIMER_W'(TIMER_INIT);
    end else if (refr_tick && !w_timer_zero) begin
      r_timer <= r_timer - TIMER_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_balls <= 2'(BALLS_INIT);
    end else begin
      case (r_state)
        ST_NEWGAME: r_balls <= w_btn_press ? 2'(BALLS_INIT - 1) : 2'(BALLS_INIT);
        ST_PLAY:    if (miss && r_balls != 2'd0) r_balls <= r_balls - 2'd1;
        ST_OVER:    if (w_timer_zero) r_balls <= 2'(BALLS_INIT);
        default:    r_balls <= r_balls;
      endcase
    end
  end

  pong_bcd_score u_score (
    .clk (clk),
    .rst (rst),
    .clr (w_score_clr),
    .inc (w_score_inc),
    .d1  (score_d1),
    .d0  (score_d0)
  );

  assign gra_still  = r_gra_still;
  assign text_sel   = r_text_sel;
  assign balls_left = r_balls;
  assign game_over  = r_game_over;

endmodule

`default_nettype wire

// File: tb/tb_pong_game_ctrl.sv
// +--------------------------------------------------------------------------+
// | tb_pong_game_ctrl : vector table, directed game sequences, random vs model|
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_pong_game_ctrl;

  localparam int BALLS = 3;
  localparam int TINIT = 127;

  localparam int P_NG   = 0;
  localparam int P_PLAY = 1;
  localparam int P_NB   = 2;
  localparam int P_OVER = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       refr_tick = 1'b0;
  logic [1:0] btn = 2'b00;
  logic       hit = 1'b0;
  logic       miss = 1'b0;
  logic       gra_still;
  logic [1:0] text_sel;
  logic [3:0] score_d1;
  logic [3:0] score_d0;
  logic [1:0] balls_left;
  logic       game_over;

  int total = 0;
  int bad   = 0;

  int m_phase = P_NG;
  int m_balls = BALLS;
  int m_score = 0;
  int m_timer = 0;

  typedef struct {
    logic [1:0]  b;
    logic        h;
    logic        m;
    logic        t;
    logic        r;
    logic [13:0] exp;
  } vec_t;

  vec_t tv[14];

  pong_game_ctrl #(.BALLS_INIT(BALLS), .TIMER_W(7), .TIMER_INIT(TINIT)) dut (
    .clk        (clk),
    .rst        (rst),
    .refr_tick  (refr_tick),
    .btn        (btn),
    .hit        (hit),
    .miss       (miss),
    .gra_still  (gra_still),
    .text_sel   (text_sel),
    .score_d1   (score_d1),
    .score_d0   (score_d0),
    .balls_left (balls_left),
    .game_over  (game_over)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [13:0] pk(input logic s, input logic [1:0] tx,
                                     input logic [7:0] sc, input logic [1:0] bl,
                                     input logic go);
    return {s, tx, sc, bl, go};
  endfunction

  function automatic vec_t mk(input logic [1:0] b, input logic h, input logic m,
                              input logic t, input logic r, input logic [13:0] e);
    vec_t v;
    v.b = b; v.h = h; v.m = m; v.t = t; v.r = r; v.exp = e;
    return v;
  endfunction

  function automatic logic [13:0] dut_out();
    return {gra_still, text_sel, score_d1, score_d0, balls_left, game_over};
  endfunction

  // expected outputs derived from the integer game model
  function automatic logic [13:0] model_out();
    logic [1:0] tx;
    logic [3:0] t1, t0;
    tx = 2'(m_phase);
    t1 = 4'(m_score / 10);
    t0 = 4'(m_score % 10);
    return {m_phase != P_PLAY, tx, t1, t0, 2'(m_balls), m_phase == P_OVER};
  endfunction

  task automatic check(input string name, input logic [13:0] act, input logic [13:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (still,text,d1,d0,balls,over)", name, act, exp);
    end
  endtask

  task automatic model_step(input logic [1:0] b, input logic h, input logic m,
                            input logic t, input logic r);
    int old_t;
    bit loaded;
    old_t  = m_timer;
    loaded = 0;
    if (r) begin
      m_phase = P_NG; m_balls = BALLS; m_score = 0; m_timer = 0;
    end else begin
      case (m_phase)
        P_NG: if (b != 0) begin m_phase = P_PLAY; m_balls = BALLS - 1; end
        P_PLAY: begin
          if (m) begin
            loaded  = 1;
            m_timer = TINIT;
            if (m_balls == 0) m_phase = P_OVER;
            else begin m_balls = m_balls - 1; m_phase = P_NB; end
          end else if (h) begin
            m_score = (m_score + 1) % 100;
          end
        end
        P_NB: if (old_t == 0 && b != 0) m_phase = P_PLAY;
        default: if (old_t == 0) begin m_phase = P_NG; m_score = 0; m_balls = BALLS; end
      endcase
      if (!loaded && t && m_timer > 0) m_timer = m_timer - 1;
    end
  endtask

  task automatic cycle(input logic [1:0] b, input logic h, input logic m,
                       input logic t, input logic r);
    btn = b; hit = h; miss = m; refr_tick = t; rst = r;
    @(posedge clk);
    model_step(b, h, m, t, r);
    #1;
    check("model", dut_out(), model_out());
  endtask

  task automatic idle(input int n, input logic [1:0] b);
    for (int i = 0; i < n; i++) cycle(b, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // n ticks, each followed by a quiet cycle
  task automatic ticks(input int n, input logic [1:0] b);
    for (int i = 0; i < n; i++) begin
      cycle(b, 1'b0, 1'b0, 1'b1, 1'b0);
      cycle(b, 1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic hits(input int n);
    for (int i = 0; i < n; i++) cycle(2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    tv[0]  = mk(2'b00, 1'b0, 1'b0, 1'b0, 1'b1, pk(1'b1, 2'b00, 8'h00, 2'd3, 1'b0));
    tv[1]  = mk(2'b00, 1'b0, 1'b0, 1'b0, 1'b0, pk(1'b1, 2'b00, 8'h00, 2'd3, 1'b0));
    tv[2]  = mk(2'b01, 1'b0, 1'b0, 1'b0, 1'b0, pk(1'b0, 2'b01, 8'h00, 2'd2, 1'b0));
    tv[3]  = mk(2'b00, 1'b1, 1'b0, 1'b0, 1'b0, pk(1'b0, 2'b01, 8'h01, 2'd2, 1'b0));
    tv[4]  = mk(2'b00, 1'b1, 1'b0, 1'b0, 1'b0, pk(1'b0, 2'b01, 8'h02, 2'd2, 1'b0));
    tv[5]  = mk(2'b00, 1'b1, 1'b1, 1'b0, 1'b0, pk(1'b1, 2'b10, 8'h02, 2'd1, 1'b0));
    tv[6]  = mk(2'b00, 1'b1, 1'b0, 1'b0, 1'b0, pk(1'b1, 2'b10, 8'h02, 2'd1, 1'b0));
    tv[7]  = mk(2'b11, 1'b0, 1'b0, 1'b1, 1'b0, pk(1'b1, 2'b10, 8'h02, 2'd1, 1'b0));
    tv[8]  = mk(2'b00, 1'b0, 1'b1, 1'b0, 1'b0, pk(1'b1, 2'b10, 8'h02, 2'd1, 1'b0));
    tv[9]  = mk(2'b00, 1'b0, 1'b0, 1'b0, 1'b1, pk(1'b1, 2'b00, 8'h00, 2'd3, 1'b0));
    tv[10] = mk(2'b00, 1'b0, 1'b1, 1'b0, 1'b0, pk(1'b1, 2'b00, 8'h00, 2'd3, 1'b0));
    tv[11] = mk(2'b10, 1'b0, 1'b0, 1'b0, 1'b0, pk(1'b0, 2'b01, 8'h00, 2'd2, 1'b0));
    tv[12] = mk(2'b00, 1'b1, 1'b0, 1'b0, 1'b0, pk(1'b0, 2'b01, 8'h01, 2'd2, 1'b0));
    tv[13] = mk(2'b01, 1'b1, 1'b0, 1'b0, 1'b1, pk(1'b1, 2'b00, 8'h00, 2'd3, 1'b0));

    for (int i = 0; i < 14; i++) begin
      cycle(tv[i].b, tv[i].h, tv[i].m, tv[i].t, tv[i].r);
      check($sformatf("vec%0d", i), dut_out(), tv[i].exp);
    end

    // long idle after reset
    cycle(2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(1000, 2'b00);
    check("idle1000", dut_out(), pk(1'b1, 2'b00, 8'h00, 2'd3, 1'b0));

    cycle(2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
    check("start", dut_out(), pk(1'b0, 2'b01, 8'h00, 2'd2, 1'b0));
    hits(12);
    check("score12", dut_out(), pk(1'b0, 2'b01, 8'h12, 2'd2, 1'b0));

    // 99 then wrap to 00
    cycle(2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle(2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
    hits(99);
    check("score99", dut_out(), pk(1'b0, 2'b01, 8'h99, 2'd2, 1'b0));
    hits(1);
    check("wrap00", dut_out(), pk(1'b0, 2'b01, 8'h00, 2'd2, 1'b0));

    hits(5);
    check("score05", dut_out(), pk(1'b0, 2'b01, 8'h05, 2'd2, 1'b0));
    cycle(2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
    check("rst_midplay", dut_out(), pk(1'b1, 2'b00, 8'h00, 2'd3, 1'b0));

    // full game: three misses, NEWBALL timeout with button held early
    cycle(2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
    check("miss1", dut_out(), pk(1'b1, 2'b10, 8'h00, 2'd1, 1'b0));
    ticks(126, 2'b11);
    check("nb_hold", dut_out(), pk(1'b1, 2'b10, 8'h00, 2'd1, 1'b0));
    cycle(2'b10, 1'b0, 1'b0, 1'b1, 1'b0);
    check("nb_tick127", dut_out(), pk(1'b1, 2'b10, 8'h00, 2'd1, 1'b0));
    cycle(2'b10, 1'b0, 1'b0, 1'b0, 1'b0);
    check("nb_exit", dut_out(), pk(1'b0, 2'b01, 8'h00, 2'd1, 1'b0));
    cycle(2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
    check("miss2", dut_out(), pk(1'b1, 2'b10, 8'h00, 2'd0, 1'b0));
    ticks(127, 2'b00);
    cycle(2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
    check("nb_exit2", dut_out(), pk(1'b0, 2'b01, 8'h00, 2'd0, 1'b0));
    hits(7);
    cycle(2'b00, 1'b0, 1'b1, 1'b1, 1'b0);
    check("over", dut_out(), pk(1'b1, 2'b11, 8'h07, 2'd0, 1'b1));
    ticks(126, 2'b00);
    idle(3, 2'b01);
    check("over_hold", dut_out(), pk(1'b1, 2'b11, 8'h07, 2'd0, 1'b1));
    cycle(2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
    cycle(2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    check("over_exit", dut_out(), pk(1'b1, 2'b00, 8'h00, 2'd3, 1'b0));

    // randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      logic [1:0] rb;
      logic rh, rm, rt, rr;
      rb = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      rh = ($urandom_range(0, 3) == 0);
      rm = ($urandom_range(0, 39) == 0);
      rt = ($urandom_range(0, 2) == 0);
      rr = ($urandom_range(0, 499) == 0);
      cycle(rb, rh, rm, rt, rr);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
